// File: rtl/rol_seq_ctrl.sv
// Multi-cycle rotate-left sequencer: splits a 0-31 rotate into ALU passes of at most 3.
// Optional macro ROL_SEQ_MOD_REDUCE_EN reduces the amount modulo 5 at load time.
module rol_seq_ctrl #(
    parameter int WIDTH    = 5,
    parameter int AMT_W    = 5,
    parameter int MAX_STEP = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    output logic [1:0]       fsm_state
);

    // Handshake: start is sampled only in IDLE (ignored, not queued, otherwise); done is a
    // one-cycle pulse with result valid in that same cycle; busy covers RUN and DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [AMT_W-1:0] rem, rem_next, load_amt;
    logic [1:0]       step;

`ifdef ROL_SEQ_MOD_REDUCE_EN
    // Subtract chain 20/10/5 covers every 5-bit amount without a divider.
    function automatic logic [AMT_W-1:0] mod5(input logic [AMT_W-1:0] x);
        logic [AMT_W-1:0] v;
        v = x;
        if (v >= AMT_W'(20)) v = v - AMT_W'(20);
        if (v >= AMT_W'(10)) v = v - AMT_W'(10);
        if (v >= AMT_W'(5))  v = v - AMT_W'(5);
        return v;
    endfunction
    assign load_amt = mod5(amt);
`else
    assign load_amt = amt;
`endif

    always_comb begin
        state_next = state;
        acc_next   = acc;
        rem_next   = rem;
        alu_b      = '0;
        step       = (rem > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = a_in;
                    rem_next   = load_amt;
                    state_next = (load_amt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                alu_b    = {{(WIDTH-2){1'b0}}, step};
                acc_next = alu_r;
                rem_next = rem - AMT_W'(step);
                if (rem_next == '0) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // result is captured on the edge entering DONE so it lines up with the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            rem   <= rem_next;
            if (state_next == DONE && state != DONE) result <= acc_next;
        end
    end

    assign alu_a     = acc;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_rol_seq_ctrl.sv
// Directed bench for rol_seq_ctrl with a behavioural rotate-by-0..3 ALU model.
module tb_rol_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] a_in = '0;
    logic [4:0] amt = '0;
    logic       busy, done;
    logic [4:0] result, alu_a, alu_b, alu_r;
    logic [1:0] fsm_state;
    logic [9:0] rot_tmp;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    rol_seq_ctrl #(.WIDTH(5), .AMT_W(5), .MAX_STEP(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .amt(amt),
        .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .fsm_state(fsm_state)
    );

    // ALU rotate slice: rotate left by B[1:0], modulo 5
    assign rot_tmp = {alu_a, alu_a} << alu_b[1:0];
    assign alu_r   = rot_tmp[9:5];

    always #5 clk = ~clk;

    task automatic run_op(input logic [4:0] a, input logic [4:0] am, input bit junk,
                          output int lat, output logic [4:0] res);
        obs_q.delete();
        lat = -1;
        res = 'x;
        @(negedge clk);
        start = 1'b1; a_in = a; amt = am;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin lat = n; res = result; break; end
            if (fsm_state == 2'd1) obs_q.push_back(alu_b);
            if (junk) begin start = 1'b1; a_in = 5'b11111; amt = 5'd3; end
            else start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (result !== 5'd0) begin errors++; $display("FAIL reset_result got %b exp 00000", result); end
        checks++; if (alu_a !== 5'd0 || alu_b !== 5'd0) begin errors++; $display("FAIL reset_alu got a=%b b=%b exp 0/0", alu_a, alu_b); end
        rst = 1'b0;
    endtask

    task automatic test_rol_one();
        int lat; logic [4:0] res;
        exp_q = '{5'd1};
        run_op(5'b00001, 5'd1, 1'b0, lat, res);
        checks++; if (lat !== 2) begin errors++; $display("FAIL one_latency got %0d exp 2", lat); end
        checks++; if (res !== 5'b00010) begin errors++; $display("FAIL one_result got %b exp 00010", res); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL one_steps got %0d exp %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL one_alu_b[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || fsm_state !== 2'd0) begin
            errors++; $display("FAIL one_after_done got done=%b busy=%b state=%0d exp 0/0/0", done, busy, fsm_state);
        end
        checks++; if (result !== 5'b00010) begin errors++; $display("FAIL one_result_hold got %b exp 00010", result); end
    endtask

    task automatic test_rol_seven();
        int lat; logic [4:0] res; int exp_lat;
`ifdef ROL_SEQ_MOD_REDUCE_EN
        exp_q = '{5'd2}; exp_lat = 2;
`else
        exp_q = '{5'd3, 5'd3, 5'd1}; exp_lat = 4;
`endif
        run_op(5'b00001, 5'd7, 1'b0, lat, res);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL seven_latency got %0d exp %0d", lat, exp_lat); end
        checks++; if (res !== 5'b00100) begin errors++; $display("FAIL seven_result got %b exp 00100", res); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL seven_steps got %0d exp %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL seven_alu_b[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_rol_zero();
        int lat; logic [4:0] res;
        run_op(5'b10110, 5'd0, 1'b0, lat, res);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d exp 1", lat); end
        checks++; if (res !== 5'b10110) begin errors++; $display("FAIL zero_result got %b exp 10110", res); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_steps got %0d exp 0", obs_q.size()); end
        checks++; if (alu_b !== 5'd0 || alu_a !== 5'b10110) begin errors++; $display("FAIL zero_alu got a=%b b=%b exp 10110/0", alu_a, alu_b); end
    endtask

    task automatic test_rol_max();
        int lat; logic [4:0] res; int exp_lat;
        exp_q.delete();
`ifdef ROL_SEQ_MOD_REDUCE_EN
        exp_q.push_back(5'd1); exp_lat = 2;
`else
        for (int i = 0; i < 10; i++) exp_q.push_back(5'd3);
        exp_q.push_back(5'd1); exp_lat = 12;
`endif
        run_op(5'b00011, 5'd31, 1'b0, lat, res);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL max_latency got %0d exp %0d", lat, exp_lat); end
        checks++; if (res !== 5'b00110) begin errors++; $display("FAIL max_result got %b exp 00110", res); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL max_steps got %0d exp %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL max_alu_b[%0d] got %0d exp %0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mod_multiple();
        int lat; logic [4:0] res; int exp_lat;
`ifdef ROL_SEQ_MOD_REDUCE_EN
        exp_lat = 1;
`else
        exp_lat = 5;
`endif
        run_op(5'b00101, 5'd10, 1'b0, lat, res);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL ten_latency got %0d exp %0d", lat, exp_lat); end
        checks++; if (res !== 5'b00101) begin errors++; $display("FAIL ten_result got %b exp 00101", res); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [4:0] res;
        run_op(5'b00001, 5'd4, 1'b1, lat, res);
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_first_latency got %0d exp 3", lat); end
        checks++; if (res !== 5'b10000) begin errors++; $display("FAIL b2b_first_result got %b exp 10000", res); end
        run_op(5'b01000, 5'd3, 1'b0, lat, res);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_second_latency got %0d exp 2", lat); end
        checks++; if (res !== 5'b00010) begin errors++; $display("FAIL b2b_second_result got %b exp 00010", res); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [4:0] res; int seen_done;
        @(negedge clk);
        start = 1'b1; a_in = 5'b00001; amt = 5'd9;
        @(negedge clk);
        start = 1'b0;
        checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL mid_run_state got %0d exp 1", fsm_state); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (fsm_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ctrl got state=%0d busy=%b done=%b exp 0/0/0", fsm_state, busy, done);
        end
        checks++; if (result !== 5'd0 || alu_a !== 5'd0) begin errors++; $display("FAIL mid_reset_data got result=%b alu_a=%b exp 0/0", result, alu_a); end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL mid_no_done got %0d active cycles exp 0", seen_done); end
        run_op(5'b00001, 5'd2, 1'b0, lat, res);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_next_latency got %0d exp 2", lat); end
        checks++; if (res !== 5'b00100) begin errors++; $display("FAIL mid_next_result got %b exp 00100", res); end
    endtask

    initial begin
        test_reset();
        test_rol_one();
        test_rol_seven();
        test_rol_zero();
        test_rol_max();
        test_mod_multiple();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
